// File: rtl/moka_imem_loader_if.sv
// Byte-stream receive and instruction-memory write bundle
// for the moka_rv32 boot loader.
interface moka_imem_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wd
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wd
  );
endinterface

// File: rtl/moka_imem_loader.sv
// Boot loader: byte stream -> LE words -> imem, then core_en.
// Define LOADER_CHECKSUM_EN for the trailing mod-256 checksum byte.
module moka_imem_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_CAPACITY = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  moka_imem_loader_if.slave   bus,
  output logic                core_en,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e S_FIN = S_CHECK;
`else
  localparam state_e S_FIN = S_DONE;
`endif

  localparam logic [15:0] CAP = 16'(MEM_CAPACITY);

  state_e                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           buf_q, buf_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic                  core_en_q, core_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic        rdy;
  logic        acc;
  logic [15:0] n_len;

  function automatic logic in_load(state_e s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) ||
`ifdef LOADER_CHECKSUM_EN
           (s == S_CHECK) ||
`endif
           (s == S_DATA);
  endfunction

  always_comb begin
    rdy = en && in_load(state_q);
    acc = rdy && bus.rx_valid;
    n_len = {bus.rx_data, n_q[7:0]};
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d = acc ? 8'(sum_q + bus.rx_data) : sum_q;
`endif
    if (en) begin
      unique case (state_q)
        S_IDLE: state_d = S_LEN_LO;
        S_LEN_LO: begin
          if (acc) begin
            n_d[7:0] = bus.rx_data;
            state_d  = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (acc) begin
            n_d[15:8] = bus.rx_data;
            if (n_len > CAP)
              state_d = S_ERROR;
            else if (n_len == 16'd0)
              state_d = S_FIN;
            else
              state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (acc) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: buf_d[7:0]   = bus.rx_data;
              2'd1: buf_d[15:8]  = bus.rx_data;
              2'd2: buf_d[23:16] = bus.rx_data;
              default: begin
                mem_we_d   = 1'b1;
                mem_wd_d   = DATA_WIDTH'({bus.rx_data, buf_q});
                mem_addr_d = DATA_WIDTH'({word_idx_q, 2'b00});
                word_idx_d = word_idx_q + 16'd1;
                if (word_idx_q == n_q - 16'd1)
                  state_d = S_FIN;
              end
            endcase
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (acc)
            state_d = (sum_d == 8'd0) ? S_DONE : S_ERROR;
        end
`endif
        default: ;
      endcase
    end
    busy_d    = in_load(state_d);
    done_d    = done_q | (state_d == S_DONE);
    error_d   = error_q | (state_d == S_ERROR);
    // core_en trails done by one edge so the last write lands first
    core_en_d = core_en_q | (en & done_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      core_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      core_en_q  <= core_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.rx_ready = rdy;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign core_en      = core_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_moka_imem_loader.sv
// Randomized image loads for moka_imem_loader against
// a byte-list reference model of the image format.
module tb_moka_imem_loader;
  localparam int CAP = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic core_en, busy, done, error;

  moka_imem_loader_if #(.DATA_WIDTH(32)) bus();

  moka_imem_loader #(
    .DATA_WIDTH(32),
    .MEM_CAPACITY(CAP)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .bus(bus),
    .core_en(core_en),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] got_q[$];
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  logic prev_core = 1'b0;
  int done_cyc = -1;
  int core_cyc = -1;
  int dbl_we = 0;

  always @(negedge clk) begin
    if (bus.mem_we) got_q.push_back({bus.mem_addr, bus.mem_wd});
    if (bus.mem_we && prev_we) dbl_we++;
    if (done && !prev_done) done_cyc = cyc;
    if (core_en && !prev_core) core_cyc = cyc;
    prev_we = bus.mem_we;
    prev_done = done;
    prev_core = core_en;
  end

  task automatic chk(input string tag, input logic [31:0] g,
                     input logic [31:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, g, e);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", 32'(bus.rx_ready), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wd", bus.mem_wd, 0);
    chk("rst_core_en", 32'(core_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.rx_valid = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    done_cyc = -1;
    core_cyc = -1;
    dbl_we = 0;
    rstn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    while (!bus.rx_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      chk("rx_ready_timeout", 32'(bus.rx_ready), 1);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic add_ck(inout logic [7:0] img[$], input bit bad);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s = 8'h00;
    foreach (img[i]) s = s + img[i];
    s = 8'h00 - s;
    if (bad) s = s + 8'($urandom_range(255, 1));
    img.push_back(s);
`else
    if (bad) img = img;
`endif
  endtask

  task automatic freeze();
    logic sb = busy;
    en = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'($urandom);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("frz_ready", 32'(bus.rx_ready), 0);
      chk("frz_busy", 32'(busy), 32'(sb));
      chk("frz_we", 32'(bus.mem_we), 0);
    end
    bus.rx_valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic run_image(input logic [7:0] img[$], input int gmin,
                           input int gmax, input int freeze_at,
                           input bit rst);
    int n, nsend, nw;
    bit over, exp_err;
    logic [7:0] s;
    logic [31:0] w;
    n = int'({img[1], img[0]});
    over = (n > CAP);
    exp_err = over;
    nw = over ? 0 : n;
    nsend = over ? 2 : 2 + 4 * n;
`ifdef LOADER_CHECKSUM_EN
    if (!over) begin
      nsend++;
      s = 8'h00;
      for (int i = 0; i < nsend; i++) s = s + img[i];
      exp_err = (s != 8'h00);
    end
`else
    s = 8'h00;
`endif
    if (rst) do_reset();
    en = 1'b1;
    for (int i = 0; i < nsend; i++) begin
      if (i == freeze_at) freeze();
      send_byte(img[i]);
      if (!over && i >= 2 && i < 2 + 4 * n)
        chk("we_latency", 32'(bus.mem_we), 32'(((i - 2) % 4) == 3));
      if (i == nsend - 1) begin
        chk("term_edge", {30'b0, done, error},
            exp_err ? 32'd1 : 32'd2);
        chk("core_en_late", 32'(core_en), 0);
      end
      repeat ($urandom_range(gmax, gmin)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    chk("done", 32'(done), 32'(!exp_err));
    chk("error", 32'(error), 32'(exp_err));
    chk("core_en", 32'(core_en), 32'(!exp_err));
    chk("busy_end", 32'(busy), 0);
    chk("ready_end", 32'(bus.rx_ready), 0);
    chk("n_writes", got_q.size(), nw);
    chk("we_width", dbl_we, 0);
    for (int k = 0; k < nw && k < got_q.size(); k++) begin
      w = {img[2 + 4 * k + 3], img[2 + 4 * k + 2],
           img[2 + 4 * k + 1], img[2 + 4 * k]};
      chk("wr_addr", got_q[k][63:32], 32'(4 * k));
      chk("wr_data", got_q[k][31:0], w);
    end
    if (!exp_err) chk("core_lag", core_cyc - done_cyc, 1);
  endtask

  task automatic make_img(input int n, input bit bad,
                          output logic [7:0] img[$]);
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    if (n <= CAP) begin
      for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
      add_ck(img, bad);
    end
  endtask

  logic [7:0] img[$];
  logic [7:0] basic[$];

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    #2;
    check_reset_vals();

    basic = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
              8'h93, 8'h00, 8'hA0, 8'h00};
    add_ck(basic, 1'b0);

    run_image(basic, 0, 0, -1, 1'b1);
    chk("basic_wd0", got_q.size() > 0 ? got_q[0][31:0] : 0,
        32'h00500013);
    chk("basic_wd1", got_q.size() > 1 ? got_q[1][31:0] : 0,
        32'h00A00093);
    chk("basic_addr1", got_q.size() > 1 ? got_q[1][63:32] : 0, 4);

    run_image(basic, 3, 3, -1, 1'b1);

    img = '{8'h0B, 8'h00};
    run_image(img, 0, 1, -1, 1'b1);

    img = '{8'h00, 8'h00};
    add_ck(img, 1'b0);
    run_image(img, 0, 0, -1, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_image(img, 0, 0, -1, 1'b1);
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    run_image(img, 0, 0, -1, 1'b1);
    chk("ck_bad_wd", got_q.size() > 0 ? got_q[0][31:0] : 0,
        32'h44332211);
`endif

    run_image(basic, 0, 0, 4, 1'b1);

    do_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(basic[i]);
    rstn = 1'b0;
    #1;
    check_reset_vals();
    run_image(basic, 0, 0, -1, 1'b1);

    run_image(basic, 0, 0, -1, 1'b1);
    img = '{8'h0A, 8'h00};
    for (int i = 0; i < 40; i++) img.push_back(8'($urandom));
    add_ck(img, 1'b0);
    run_image(img, 0, 0, -1, 1'b1);

    for (int it = 0; it < 14; it++) begin
      int n, fz;
      bit bad;
      n = ($urandom_range(5, 0) == 0) ? int'($urandom_range(300, CAP + 1))
                                      : int'($urandom_range(CAP, 0));
      bad = ($urandom_range(3, 0) == 0);
      make_img(n, bad, img);
      fz = (n > 0 && n <= CAP && $urandom_range(1, 0) == 1)
           ? int'($urandom_range(4 * n + 1, 2)) : -1;
      run_image(img, 0, $urandom_range(2, 0), fz, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/moka_imem_loader.md
# moka_imem_loader

Boot-time program loader for the moka_rv32 core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into the instruction memory write port from word 0 upward. It holds the core disabled until the image is complete, then releases it through `core_en`.

## Interface

Parameters:
- `DATA_WIDTH`, 32: word width. Only 32 is supported.
- `MEM_CAPACITY`, 10: instruction memory depth in words. This is the largest legal image.

Ports:
- `clk`  input  1  clock; all state changes on rising edge.
- `rstn`  input  1  reset, asynchronous, active-low.
- `en`  input  1  loader enable; low freezes all state.
- `rx_data`  input  8  incoming byte.
- `rx_valid`  input  1  `rx_data` valid.
- `rx_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  instruction memory write strobe, one-cycle pulse.
- `mem_addr`  output  DATA_WIDTH  byte address of the word being written, word-aligned.
- `mem_wd`  output  DATA_WIDTH  word to write.
- `core_en`  output  1  drives the core `en`.
- `busy`  output  1  load in progress (states LEN_LO through CHECK).
- `done`  output  1  image loaded successfully; sticky.
- `error`  output  1  load aborted; sticky.

## Operation

- **Image format:** 2-byte word count N (LSB first), then 4·N payload bytes, each word LSB first.
  - When `LOADER_CHECKSUM_EN` is defined, one trailing checksum byte follows.
- **Handshake:** a byte is accepted on a rising edge where `rx_valid && rx_ready`.
  - `rx_ready` is combinational: `en` AND state ∈ {LEN_LO, LEN_HI, DATA, CHECK}.
  - `rx_data` is ignored when not accepted.
- **FSM states:** IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
  - IDLE → LEN_LO on the first edge with `en`=1.
  - LEN_LO → LEN_HI on accept; the byte is latched as N[7:0].
  - LEN_HI → on accept, with N[15:8] latched:
    - ERROR if N > MEM_CAPACITY;
    - else CHECK if N=0 and the checksum is enabled;
    - else DONE if N=0;
    - else DATA.
  - DATA:
    - 2-bit byte counter; byte k goes to word bits [8k+7:8k].
    - On accepting byte 3: register `mem_wd` = assembled word, `mem_addr` = word_idx·4, `mem_we`=1; then increment word_idx.
    - When word_idx reaches N-1 on that edge, go to CHECK (checksum enabled) or DONE.
  - CHECK → DONE on accept if the running sum is 0, else ERROR.
  - DONE and ERROR are terminal until `rstn` is asserted.
- **Address arithmetic:** word_idx is 16 bits and never exceeds MEM_CAPACITY-1, so `mem_addr` never wraps.
- **`en` low:** no byte is accepted and no state, counter or sum changes.
  - An already-registered `mem_we` pulse still deasserts on the next edge.
  - `core_en` and `done`/`error` hold their values.
- **Reset mid-load:** everything returns to reset values and the partial image is abandoned. Words already written stay in memory.

## Timing

- Reset values: `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0, `core_en`=0, `busy`=0, `done`=0, `error`=0; state IDLE, all counters 0.
- Write latency: `mem_we` is high for exactly one cycle, starting at the edge that accepts byte 3 of a word.
  - Back-to-back words at one byte per cycle give a `mem_we` pulse every 4th cycle.
- `done` rises at the edge entering DONE.
- `core_en` rises one edge later, so the final write has been committed before the core fetches.
- `error` rises at the edge entering ERROR; `core_en` stays 0.
- `busy` is registered and reflects the current state.

## Configuration

- `LOADER_CHECKSUM_EN`:
  - **Defined:**
    - An 8-bit running sum (mod 256) covers the length bytes, the payload bytes and the checksum byte.
    - The checksum byte is expected to make that sum 0.
    - A non-zero sum after CHECK goes to ERROR.
  - **Undefined:**
    - The CHECK state and the sum register are not present.
    - The last payload byte (or LEN_HI when N=0) goes directly to DONE.

## Test plan

- **Basic load, checksum off:** bytes 02 00 13 00 50 00 93 00 A0 00 at one per cycle. Expected:
  - `mem_we` pulses with addr 0 / wd 0x00500013, then addr 4 / wd 0x00A00093;
  - `done`=1, then `core_en`=1 on the next edge.
- **Backpressure and gaps:** same image with `rx_valid` low for 3 cycles between every byte. Expected: identical writes; no `mem_we` during gaps.
- **Oversize image:** N=11 (0B 00) with MEM_CAPACITY=10. Expected:
  - `error`=1 after LEN_HI;
  - `rx_ready`=0 afterwards, no `mem_we` ever, `core_en` stays 0.
- **Checksum on:** image 01 00 11 22 33 44 plus checksum 0x55 → DONE. The same image with checksum 0x56 → ERROR after one write (addr 0, wd 0x44332211).
- **Freeze:** drop `en` after 2 payload bytes for 5 cycles while `rx_valid`=1. Expected: `rx_ready`=0 and no state change; the load resumes and the word is assembled correctly.
- **Reset mid-load and N=0:**
  - Assert `rstn`=0 between bytes 1 and 2 of a word → all outputs return to reset values, and a fresh image then loads from addr 0.
  - N=0 (00 00, checksum off) → DONE with no `mem_we`.
